tt_pin_driver: RTL



---
 rtl/tt_drv_pkg.sv | 27 ++
 rtl/tt_drv_counter.sv | 23 ++
 rtl/tt_pin_driver.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tt_drv_pkg.sv
// Shared types and constants for the Tiny Tapeout pin driver.
// Opcode and FSM enums, response width and the error-count ceiling.
package tt_drv_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SET_UI  = 3'd1,
    OP_SET_UIO = 3'd2,
    OP_SET_ENA = 3'd3,
    OP_RESET   = 3'd4,
    OP_WAIT    = 3'd5,
    OP_SAMPLE  = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam int         RSP_W   = 24;
  localparam logic [7:0] ERR_MAX = 8'hFF;

endpackage

// File: rtl/tt_drv_counter.sv
// Loadable down-counter shared by the RST, WAIT and SETTLE phases.
// done is high while the count sits at 1, i.e. in the last cycle of a phase.
module tt_drv_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/tt_pin_driver.sv
// Command-driven pin driver for a tt_um_* user design: sets inputs, pulses reset,
// waits and samples outputs. Define TT_DRV_COMPARE_EN to add the masked compare on SAMPLE.
module tt_pin_driver
  import tt_drv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [7:0]       cmd_arg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RSP_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [7:0]       err_count,
  output logic [7:0]       dut_ui_in,
  output logic [7:0]       dut_uio_in,
  output logic             dut_ena,
  output logic             dut_rst_n,
  input  logic [7:0]       dut_uo_out,
  input  logic [7:0]       dut_uio_out,
  input  logic [7:0]       dut_uio_oe
);

  state_e           state, state_nxt;
  op_e              op;
  logic             accept, rdy_en, cnt_load, cnt_done, capture;
  logic [CNT_W-1:0] cnt_val;

  assign op      = op_e'(cmd_op);
  assign accept  = cmd_valid && cmd_ready;
  assign capture = (state == ST_SETTLE) && cnt_done;

  tt_drv_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // rdy_en keeps cmd_ready low for as long as rst_n is held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      ST_IDLE: if (accept) begin
        case (op)
          OP_RESET: begin
            state_nxt = ST_RST;
            cnt_load  = 1'b1;
            cnt_val   = (cmd_arg == 8'd0) ? CNT_W'(1) : CNT_W'(cmd_arg);
          end
          OP_WAIT: if (cmd_arg != 8'd0) begin
            state_nxt = ST_WAIT;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(cmd_arg);
          end
          OP_SAMPLE: begin
            state_nxt = ST_SETTLE;
            cnt_load  = 1'b1;
            cnt_val   = CNT_W'(SETTLE_CYCLES);
          end
          default: ;
        endcase
      end
      ST_RST, ST_WAIT: if (cnt_done) state_nxt = ST_IDLE;
      ST_SETTLE:       if (cnt_done) state_nxt = ST_RESP;
      ST_RESP:         if (rsp_ready) state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE) && rdy_en;
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
      dut_ena    <= 1'b0;
      dut_rst_n  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        case (op)
          OP_SET_UI:  dut_ui_in  <= cmd_data;
          OP_SET_UIO: dut_uio_in <= cmd_data;
          OP_SET_ENA: dut_ena    <= cmd_data[0];
          OP_RESET:   dut_rst_n  <= 1'b0;
          default: ;
        endcase
      end
      if ((state == ST_RST) && cnt_done) dut_rst_n <= 1'b1;
      if (capture) rsp_data <= {dut_uio_oe, dut_uio_out, dut_uo_out};
    end
  end

`ifdef TT_DRV_COMPARE_EN
  logic [7:0] exp_q, mask_q;
  logic       mismatch;

  assign mismatch = |((dut_uo_out ^ exp_q) & mask_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q     <= '0;
      mask_q    <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept && (op == OP_SAMPLE)) begin
        exp_q  <= cmd_data;
        mask_q <= cmd_arg;
      end
      if (capture) begin
        rsp_err <= mismatch;
        if (mismatch && (err_count != ERR_MAX)) err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign rsp_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule
